mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Arbitrates the single 16-bit external memory port between the instruction-fetch requester and the data-memory (load/store) requester of the 5-stage pipeline. Each transaction runs on a fixed-latency memory. Data accesses win by default; a bounded starvation counter guarantees forward progress for fetch. The block drives a pipeline hold signal to the hazard logic while any request is outstanding.

## Interface
Parameters:
- MEM_LAT, 1, memory read latency in cycles from the mem_en cycle to valid mem_rdata; legal range 1..15
- STARVE_MAX, 4, consecutive data grants allowed while fetch waits before fetch is forced to win; legal range 1..15

Ports:
- clock  in  1  single clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch read request; held until if_done
- if_addr  in  16  fetch address
- if_rdata  out  16  fetched instruction; valid when if_done=1
- if_done  out  1  one-cycle completion pulse for fetch
- dm_req  in  1  data request; held until dm_done
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  16  data address
- dm_wdata  in  16  store data
- dm_rdata  out  16  load data; valid when dm_done=1
- dm_done  out  1  one-cycle completion pulse for data
- mem_en  out  1  memory strobe; high for exactly one cycle per transaction
- mem_we  out  1  memory write enable; qualified by mem_en
- mem_addr  out  16  memory address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data
- pipe_hold  out  1  high while any request is pending and not yet done

## Operation
- FSM states: IDLE, ACCESS, DONE.
- **IDLE**
  - No request: stay in IDLE.
  - Otherwise select a winner. dm wins, unless if_req=1 and starve_cnt==STARVE_MAX, in which case fetch wins.
  - Latch the winner's address, write enable (fetch forces 0) and write data into the mem_* registers.
  - Load lat_cnt=MEM_LAT-1 and go to ACCESS.
- **ACCESS**
  - mem_en=1 only in the first ACCESS cycle.
  - Decrement lat_cnt each cycle.
  - When lat_cnt==0: capture mem_rdata into the winner's rdata register (loads and fetches only; a store leaves dm_rdata unchanged), then go to DONE.
- **DONE**
  - Assert the winner's done for one cycle, then go to IDLE.
- **Starvation counter** (4-bit)
  - Increments on every dm grant made while if_req=1.
  - Clears on a fetch grant.
  - Holds otherwise.
- **Requester rule:** a req still high in the cycle after its done is treated as a new request.
- **pipe_hold**: combinational, (if_req & ~if_done) | (dm_req & ~dm_done).
- **Reset**
  - rst low at any time forces IDLE, starve_cnt=0 and lat_cnt=0.
  - Forces mem_en, mem_we, if_done and dm_done to 0.
  - Forces mem_addr, mem_wdata, if_rdata and dm_rdata to 0.
  - A transaction in flight is abandoned and no done is issued.
- **Simultaneous requests in IDLE:** dm wins unless the starvation override applies; the loser is served in the next IDLE.

## Timing
- Request seen in IDLE at cycle 0:
  - mem_en at cycle 1;
  - mem_rdata sampled at the end of cycle MEM_LAT;
  - done at cycle MEM_LAT+1.
  - Total request-to-done latency is MEM_LAT+1 cycles.
- Back-to-back throughput: one transaction per MEM_LAT+2 cycles.
- done, rdata and all mem_* outputs are registered. pipe_hold is the only combinational output.

## Configuration
- **ARB_PERF_CNT_EN defined:** adds two outputs.
  - perf_hold_cnt (16): saturating count of cycles with pipe_hold=1.
  - perf_starve_cnt (16): saturating count of forced fetch grants.
  - Both counters clear on reset.
- **ARB_PERF_CNT_EN undefined:** these ports and their logic do not exist. Functional behaviour is otherwise identical.

## Structure
- Shared package mem_arb_pkg holds:
  - the state enum (IDLE, ACCESS, DONE);
  - grant-id constants GNT_IF and GNT_DM;
  - the 16-bit word width constant.
- Sub-module arb_down_counter (4-bit loadable down-counter with zero flag) implements lat_cnt.
- starve_cnt is inline.

## Test plan
- MEM_LAT=1; single fetch, if_addr=16'h0010, memory returns 16'h1234 → mem_en at cycle 1, if_done and if_rdata=16'h1234 at cycle 2, pipe_hold high cycles 0–1.
- MEM_LAT=3; store dm_addr=16'h0040, dm_wdata=16'hBEEF → one mem_en cycle with mem_we=1, mem_wdata=16'hBEEF; dm_done at cycle 4; dm_rdata unchanged.
- STARVE_MAX=2; if_req and dm_req held continuously → grant order dm, dm, if, dm, dm, if; perf_starve_cnt=2 after six grants (macro on).
- Simultaneous first requests with starve_cnt=0 → dm served first; fetch served in the next IDLE; if_done arrives MEM_LAT+2 cycles after dm_done.
- rst driven low during ACCESS with MEM_LAT=4 → mem_en, dm_done and if_done are 0 immediately; state IDLE; no done pulse after release; the next request completes normally.
- With ARB_PERF_CNT_EN undefined, the design elaborates with no perf ports and all directed scenarios above pass unchanged.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter.
//   arb_state_t   : arbiter FSM state encoding (IDLE, ACCESS, DONE)
//   GNT_IF/GNT_DM : grant identifiers for the fetch and data requesters
//   WORD_W        : width of the external memory data/address word
package mem_arb_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_DM = 1'b1;

endpackage

// File: rtl/arb_down_counter.sv
// arb_down_counter: 4-bit loadable down-counter with zero flag.
//   clock    : rising-edge clock
//   rst      : asynchronous active-low reset, clears the count
//   load     : load load_val (has priority over dec)
//   load_val : value to load
//   dec      : decrement by one
//   count    : current count
//   zero     : count == 0
module arb_down_counter (
    input  logic       clock,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic [3:0] count,
    output logic       zero
);

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            count <= 4'd0;
        end else if (load) begin
            count <= load_val;
        end else if (dec) begin
            count <= count - 4'd1;
        end
    end

    assign zero = (count == 4'd0);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 16-bit fixed-latency memory port between
// instruction fetch and data load/store. Data wins by default; a starvation
// counter forces a fetch grant after STARVE_MAX consecutive data grants made
// while fetch was waiting.
//
// Ports:
//   clock, rst                     : clock, async active-low reset
//   if_req/if_addr/if_rdata/if_done: fetch requester
//   dm_req/dm_we/dm_addr/dm_wdata/dm_rdata/dm_done : data requester
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata     : external memory port
//   pipe_hold                      : combinational hold to hazard logic
//   perf_hold_cnt, perf_starve_cnt : only with ARB_PERF_CNT_EN defined
//
// Build option ARB_PERF_CNT_EN: adds saturating counters of hold cycles and
// of forced fetch grants.
//
// state  | meaning
// IDLE   | waiting for a request; winner chosen and latched on exit
// ACCESS | memory transaction in flight, lat_cnt counting down
// DONE   | winner's done pulse is high this cycle
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              if_req,
    input  logic [WORD_W-1:0] if_addr,
    output logic [WORD_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [WORD_W-1:0] dm_addr,
    input  logic [WORD_W-1:0] dm_wdata,
    output logic [WORD_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              pipe_hold
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [15:0]       perf_hold_cnt,
    output logic [15:0]       perf_starve_cnt
`endif
);

    localparam logic [3:0] LAT_LOAD   = 4'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    arb_state_t state_q, state_d;
    logic       gnt_q;
    logic       grant;
    logic       capture;
    logic       force_if;
    logic       win_dm;
    logic [3:0] starve_cnt;
    logic [3:0] lat_cnt;
    logic       lat_zero;

    arb_down_counter u_lat_cnt (
        .clock    (clock),
        .rst      (rst),
        .load     (grant),
        .load_val (LAT_LOAD),
        .dec      ((state_q == ACCESS) && (lat_cnt != 4'd0)),
        .count    (lat_cnt),
        .zero     (lat_zero)
    );

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant    = 1'b0;
        capture  = 1'b0;
        force_if = if_req && (starve_cnt == STARVE_LIM);
        win_dm   = dm_req && !force_if;
        case (state_q)
            IDLE: begin
                if (if_req || dm_req) begin
                    grant   = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (lat_zero) begin
                    capture = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            gnt_q     <= GNT_IF;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_done   <= 1'b0;
            dm_done   <= 1'b0;
        end else begin
            // mem_en is only ever set by the IDLE->ACCESS transition, so it is
            // high for exactly the first ACCESS cycle.
            mem_en  <= grant;
            if_done <= capture && (gnt_q == GNT_IF);
            dm_done <= capture && (gnt_q == GNT_DM);
            if (grant) begin
                gnt_q     <= win_dm ? GNT_DM : GNT_IF;
                mem_addr  <= win_dm ? dm_addr : if_addr;
                mem_we    <= win_dm && dm_we;
                mem_wdata <= win_dm ? dm_wdata : '0;
            end
            if (capture) begin
                if (gnt_q == GNT_IF) begin
                    if_rdata <= mem_rdata;
                end else if (!mem_we) begin
                    dm_rdata <= mem_rdata;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            starve_cnt <= 4'd0;
        end else if (grant) begin
            if (!win_dm) begin
                starve_cnt <= 4'd0;
            end else if (if_req && (starve_cnt != 4'hF)) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

    assign pipe_hold = (if_req & ~if_done) | (dm_req & ~dm_done);

`ifdef ARB_PERF_CNT_EN
    // A forced grant is one where the override actually beat a pending data request.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            perf_hold_cnt   <= 16'd0;
            perf_starve_cnt <= 16'd0;
        end else begin
            if (pipe_hold && (perf_hold_cnt != 16'hFFFF)) begin
                perf_hold_cnt <= perf_hold_cnt + 16'd1;
            end
            if (grant && force_if && dm_req && (perf_starve_cnt != 16'hFFFF)) begin
                perf_starve_cnt <= perf_starve_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
